seq_mul32: RTL and testbench

Multi-cycle 32×32 shift-add multiplier for the 32-bit ALU datapath. It takes two operands, iterates one bit per clock, and presents a 64-bit product as HI/LO words. The LO or HI word feeds the ALU's 32-bit two-input result select mux, which picks between the combinational ALU result and the multiplier result. A START/BUSY/DONE handshake lets the control unit stall while a multiply is in flight.

---
 rtl/seq_mul32_if.sv | 22 ++
 rtl/seq_mul32.sv | 119 +++++++++++
 tb/tb_seq_mul32.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mul32_if.sv
// Operand/result bundle for the sequential 32x32 multiplier.
// master = control unit side, slave = multiplier side.
interface seq_mul32_if;
  logic        START;
  logic        SIGN;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output START, SIGN, A, B,
    input  BUSY, DONE, HI, LO
  );

  modport slave (
    input  START, SIGN, A, B,
    output BUSY, DONE, HI, LO
  );
endinterface

// File: rtl/seq_mul32.sv
// 32x32 shift-add multiplier, one bit per clock, 33-cycle latency.
// Define SIGNED_MUL_EN to build the signed (SIGN=1) magnitude/negate path.
module seq_mul32 (
  input logic        CLK,
  input logic        RST_N,
  seq_mul32_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [63:0] acc_q, acc_d;

  logic        accept;
  logic        last;
  logic [32:0] sum;
  logic [63:0] step;
  logic [63:0] fin;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

`ifdef SIGNED_MUL_EN
  logic neg_q, neg_d;
  logic sa, sb;

  assign sa    = bus.SIGN & bus.A[31];
  assign sb    = bus.SIGN & bus.B[31];
  assign mag_a = sa ? (~bus.A + 32'd1) : bus.A;
  assign mag_b = sb ? (~bus.B + 32'd1) : bus.B;
  assign fin   = neg_q ? (~step + 64'd1) : step;

  always_comb begin
    neg_d = neg_q;
    if (accept) neg_d = sa ^ sb;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end
`else
  logic unused_sign;

  assign unused_sign = bus.SIGN;
  assign mag_a       = bus.A;
  assign mag_b       = bus.B;
  assign fin         = step;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.START) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_FIN;
      S_FIN:   state_d = bus.START ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY = (state_q == S_RUN);
    bus.DONE = (state_q == S_FIN);
  end

  assign accept = bus.START & (state_q != S_RUN);
  assign last   = (cnt_q == 5'd31);

  // Multiplicand lands on the upper 33 bits, then {carry,acc} shifts right.
  assign sum  = {1'b0, acc_q[63:32]}
              + {1'b0, mplr_q[0] ? mcand_q : 32'd0};
  assign step = {sum, acc_q[31:1]};

  always_comb begin
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    if (accept) begin
      cnt_d   = 5'd0;
      mcand_d = mag_a;
      mplr_d  = mag_b;
      acc_d   = 64'd0;
    end else if (state_q == S_RUN) begin
      cnt_d  = cnt_q + 5'd1;
      mplr_d = {1'b0, mplr_q[31:1]};
      acc_d  = last ? fin : step;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= 5'd0;
      mcand_q <= 32'd0;
      mplr_q  <= 32'd0;
      acc_q   <= 64'd0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.HI = acc_q[63:32];
  assign bus.LO = acc_q[31:0];

endmodule

// File: tb/tb_seq_mul32.sv
// Directed plus random checks of seq_mul32 against a plain-arithmetic model.
module tb_seq_mul32;

  logic CLK;
  logic RST_N;
  int   tests;
  int   fails;

  seq_mul32_if bus ();

  seq_mul32 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    longint p;
`ifdef SIGNED_MUL_EN
    if (s) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
`endif
    p = 0;
    return ({32'd0, a} * {32'd0, b}) + 64'(p);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.SIGN  = s;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
  endtask

  // Called #1 after the acceptance edge; n = edges until DONE seen.
  task automatic wait_done(output int n, output int busy_n);
    n      = 0;
    busy_n = 0;
    while (!bus.DONE && n < 40) begin
      if (bus.BUSY) busy_n++;
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic run_op(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    int n, bn;
    logic [63:0] e;
    e = model(a, b, s);
    start_op(a, b, s);
    wait_done(n, bn);
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_busy"}, 64'(bn), 64'd32);
    chk({tag, "_both"}, 64'(bus.BUSY & bus.DONE), 64'd0);
    chk({tag, "_prod"}, {bus.HI, bus.LO}, e);
    @(posedge CLK);
    #1;
    chk({tag, "_pulse"}, 64'(bus.DONE), 64'd0);
    chk({tag, "_hold"}, {bus.HI, bus.LO}, e);
  endtask

  initial begin
    int n, bn, dones;
    logic [31:0] ra, rb;
    logic        rs;
    tests     = 0;
    fails     = 0;
    bus.START = 1'b0;
    bus.SIGN  = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    RST_N     = 1'b0;
    #23;
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Reset in the middle of an operation.
    start_op(32'd3, 32'd3, 1'b0);
    repeat (10) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("mid_busy", 64'(bus.BUSY), 64'd0);
    chk("mid_done", 64'(bus.DONE), 64'd0);
    chk("mid_hilo", {bus.HI, bus.LO}, 64'd0);
    #2;
    RST_N = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (bus.DONE) dones++;
    end
    chk("mid_nodone", 64'(dones), 64'd0);

    run_op("basic", 32'd7, 32'd6, 1'b0);
    chk("basic_const", {bus.HI, bus.LO}, 64'h0000_0000_0000_002A);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("max_const", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);

    run_op("sgn1", 32'hFFFF_FFFF, 32'd5, 1'b1);
`ifdef SIGNED_MUL_EN
    chk("sgn1_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op("sgn2", 32'h8000_0000, 32'h8000_0000, 1'b1);
    chk("sgn2_const", {bus.HI, bus.LO}, 64'h4000_0000_0000_0000);
`else
    chk("sgn1_const", {bus.HI, bus.LO}, 64'h0000_0004_FFFF_FFFB);
`endif

    // START during RUN must not recapture operands.
    start_op(32'd2, 32'd3, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    bus.START = 1'b1;
    bus.A     = 32'd100;
    bus.B     = 32'd100;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    wait_done(n, bn);
    chk("ign_lat", 64'(n + 6), 64'd32);
    chk("ign_prod", {bus.HI, bus.LO}, 64'd6);

    // Back-to-back with START held through FIN.
    @(posedge CLK);
    #1;
    bus.START = 1'b1;
    bus.A     = 32'd2;
    bus.B     = 32'd3;
    bus.SIGN  = 1'b0;
    @(posedge CLK);
    #1;
    wait_done(n, bn);
    chk("b2b1_lat", 64'(n), 64'd32);
    chk("b2b1_prod", {bus.HI, bus.LO}, 64'd6);
    bus.A = 32'd4;
    bus.B = 32'd5;
    @(posedge CLK);
    #1;
    wait_done(n, bn);
    chk("b2b2_lat", 64'(n + 1), 64'd33);
    chk("b2b2_prod", {bus.HI, bus.LO}, 64'd20);
    bus.START = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'd0;
      if (i == 2) rb = 32'hFFFF_FFFF;
      run_op("rand", ra, rb, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
